// File: rtl/dense_layer_sequencer.sv
// Final dense-layer sequencer: per-neuron MAC over the flattened features, bias add, valid/ready score stream.
// Optional ARGMAX_EN adds a running signed argmax reported alongside done.
module dense_layer_sequencer #(
  parameter int N_IN   = 128,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(N_IN)-1:0]          featAdr,
  input  logic signed [DATA_W-1:0]         featData,
  output logic [$clog2(N_IN*N_OUT)-1:0]    wAdr,
  input  logic signed [DATA_W-1:0]         wData,
  output logic [$clog2(N_OUT)-1:0]         biasAdr,
  input  logic signed [ACC_W-1:0]          biasData,
  output logic signed [ACC_W-1:0]          outData,
  output logic [$clog2(N_OUT)-1:0]         outIdx,
  output logic                             outValid,
  input  logic                             outReady,
  output logic [$clog2(N_OUT)-1:0]         classIdx,
  output logic                             classValid
);
  localparam int IW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT);
  localparam int WW = $clog2(N_IN*N_OUT);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_OUT, S_DONE} state_t;

  state_t                    state_q;
  logic [IW-1:0]             i_q;
  logic [OW-1:0]             n_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d, score_d;
  logic signed [ACC_W-1:0]   out_data_q;
  logic [OW-1:0]             out_idx_q;
  logic                      out_valid_q, done_q, addr_en;
  logic signed [2*DATA_W-1:0] prod;

  assign prod    = featData * wData;
  assign acc_d   = acc_q + ACC_W'(prod);
  assign score_d = acc_q + biasData;

  // Counters are frozen outside MAC, so addresses hold through a stalled output.
  assign addr_en = (state_q != S_IDLE) && (state_q != S_DONE);
  assign featAdr = addr_en ? i_q : '0;
  assign wAdr    = addr_en ? WW'(int'(n_q) * N_IN + int'(i_q)) : '0;
  assign biasAdr = addr_en ? n_q : '0;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign outData  = out_data_q;
  assign outIdx   = out_idx_q;
  assign outValid = out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_MAC;
            i_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (i_q == IW'(N_IN-1)) state_q <= S_BIAS;
          else                    i_q     <= i_q + IW'(1);
        end
        S_BIAS: begin
          out_data_q  <= score_d;
          out_idx_q   <= n_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (outReady) begin
            out_valid_q <= 1'b0;
            if (n_q == OW'(N_OUT-1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              n_q     <= n_q + OW'(1);
              i_q     <= '0;
              acc_q   <= '0;
              state_q <= S_MAC;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ARGMAX_EN
  logic signed [ACC_W-1:0] max_q;
  logic [OW-1:0]           max_idx_q, class_idx_q, best_idx;
  logic                    class_valid_q, take_new;

  // Strict compare keeps the lowest index on ties; neuron 0 always seeds the max.
  assign take_new = (out_idx_q == '0) || (out_data_q > max_q);
  assign best_idx = take_new ? out_idx_q : max_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q         <= '0;
      max_idx_q     <= '0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      if (state_q == S_IDLE && start) class_idx_q <= '0;
      if (state_q == S_OUT && outReady) begin
        if (take_new) begin
          max_q     <= out_data_q;
          max_idx_q <= out_idx_q;
        end
        if (n_q == OW'(N_OUT-1)) begin
          class_idx_q   <= best_idx;
          class_valid_q <= 1'b1;
        end
      end
    end
  end

  assign classIdx   = class_idx_q;
  assign classValid = class_valid_q;
`else
  assign classIdx   = '0;
  assign classValid = 1'b0;
`endif

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Self-checking bench for dense_layer_sequencer (N_IN=4, N_OUT=10) against an arithmetic reference model.
module tb_dense_layer_sequencer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 10;

  logic clk = 1'b0;
  logic rst, start, outReady;
  logic busy, done, outValid, classValid;
  logic [1:0]  featAdr;
  logic [5:0]  wAdr;
  logic [3:0]  biasAdr, outIdx, classIdx;
  logic signed [15:0] featData, wData;
  logic signed [31:0] biasData, outData;

  logic signed [15:0] feat [N_IN];
  logic signed [15:0] w    [N_IN*N_OUT];
  logic [31:0]        bias [N_OUT];

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [31:0] hs_data [N_OUT];
  logic [3:0]  hs_idx  [N_OUT];
  int          hs_cyc  [N_OUT];
  int hs_n, done_cnt, done_cyc, cv_stray;
  logic [3:0] ci_at_done;
  logic       cv_at_done;

  always #5 clk = ~clk;

  assign featData = feat[featAdr];
  assign wData    = (int'(wAdr) < N_IN*N_OUT) ? w[wAdr] : 16'sd0;
  assign biasData = (int'(biasAdr) < N_OUT) ? bias[biasAdr] : 32'sd0;

  dense_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .featAdr(featAdr), .featData(featData), .wAdr(wAdr), .wData(wData),
    .biasAdr(biasAdr), .biasData(biasData), .outData(outData), .outIdx(outIdx),
    .outValid(outValid), .outReady(outReady), .classIdx(classIdx), .classValid(classValid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_real_bias();
    bias[0] = 32'h012598B0; bias[1] = 32'h0B1A26D0; bias[2] = 32'hFE3C1A80;
    bias[3] = 32'h04D2E110; bias[4] = 32'hF9A0B3C0; bias[5] = 32'h0077AA10;
    bias[6] = 32'h0A11F0E0; bias[7] = 32'hFD5566A0; bias[8] = 32'h03B9C2F0;
    bias[9] = 32'hFFA37200;
  endtask

  task automatic fill(input int fv, input int wv, input bit rnd);
    for (int i = 0; i < N_IN; i++) feat[i] = rnd ? 16'($urandom) : 16'(fv);
    for (int j = 0; j < N_IN*N_OUT; j++) w[j] = rnd ? 16'($urandom) : 16'(wv);
  endtask

  // Runs one pass from a start pulse; optionally stalls one neuron and re-pulses start mid-pass / in DONE.
  task automatic run_pass(input int stall_k, input int stall_len, input bit repulse);
    logic [63:0] snap;
    int stall_cnt = 0, chk_cyc = -1;
    hs_n = 0; done_cnt = 0; done_cyc = -1; cv_stray = 0;
    ci_at_done = '0; cv_at_done = 1'b0; snap = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      outReady = 1'b1;
      if (cyc == chk_cyc) check("next_mac_wadr", 64'(wAdr), 64'((stall_k+1)*N_IN));
      if (outValid && int'(outIdx) == stall_k && stall_cnt < stall_len) begin
        outReady = 1'b0;
        if (stall_cnt == 0) snap = {16'h0, outData, outIdx, featAdr, wAdr, biasAdr};
        else check("stall_hold", {16'h0, outData, outIdx, featAdr, wAdr, biasAdr}, snap);
        stall_cnt++;
      end
      if (outValid && outReady) begin
        if (hs_n < N_OUT) begin
          hs_data[hs_n] = outData; hs_idx[hs_n] = outIdx; hs_cyc[hs_n] = cyc;
        end
        if (stall_len > 0 && int'(outIdx) == stall_k && stall_k < N_OUT-1) chk_cyc = cyc + 1;
        hs_n++;
      end
      if (classValid && !done) cv_stray++;
      if (done) begin
        done_cyc = cyc; done_cnt++;
        ci_at_done = classIdx; cv_at_done = classValid;
        if (repulse) start = 1'b1;
      end
      if (repulse && cyc == 3) start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (done_cyc < 0) check("pass_timeout", 64'd0, 64'd1);
  endtask

  task automatic verify_pass(input string tag, input int stall_k, input int stall_len);
    logic [31:0] s [N_OUT];
    logic [31:0] acc;
    int best, ecyc;
    for (int n = 0; n < N_OUT; n++) begin
      acc = bias[n];
      for (int i = 0; i < N_IN; i++) acc = acc + 32'(int'(feat[i]) * int'(w[n*N_IN+i]));
      s[n] = acc;
    end
    best = 0;
    for (int n = 1; n < N_OUT; n++) if ($signed(s[n]) > $signed(s[best])) best = n;
    check({tag, "_hs_count"}, 64'(hs_n), 64'(N_OUT));
    for (int k = 0; k < N_OUT; k++) begin
      ecyc = (k+1)*(N_IN+2) + ((k >= stall_k) ? stall_len : 0);
      check($sformatf("%s_idx%0d", tag, k), 64'(hs_idx[k]), 64'(k));
      check($sformatf("%s_score%0d", tag, k), 64'(hs_data[k]), 64'(s[k]));
      check($sformatf("%s_cyc%0d", tag, k), 64'(hs_cyc[k]), 64'(ecyc));
    end
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(N_OUT*(N_IN+2) + 1 + ((stall_k < N_OUT) ? stall_len : 0)));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_cv_stray"}, 64'(cv_stray), 64'd0);
`ifdef ARGMAX_EN
    check({tag, "_class_idx"}, 64'(ci_at_done), 64'(best));
    check({tag, "_class_valid"}, 64'(cv_at_done), 64'd1);
`else
    check({tag, "_class_idx"}, 64'(ci_at_done), 64'd0);
    check({tag, "_class_valid"}, 64'(cv_at_done), 64'd0);
`endif
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (busy || done || featAdr != 0 || wAdr != 0 || biasAdr != 0) seen++;
      tick();
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int hs, seen_done;
    rst = 1'b1; start = 1'b0; outReady = 1'b1;
    load_real_bias();
    fill(1, 1, 1'b0);
    tick(); tick();
    check("reset_outputs", {busy, done, outValid, outData, outIdx, featAdr, wAdr, biasAdr, classIdx, classValid}, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", {busy, done, outValid, featAdr, wAdr, biasAdr}, 64'd0);

    // Unit data: scores are bias + N_IN.
    run_pass(99, 0, 1'b0);
    verify_pass("unit", 99, 0);
    check("unit_n9_const", 64'(hs_data[9]), 64'h00000000FFA37204);
    check("unit_n0_const", 64'(hs_data[0]), 64'h00000000012598B4);
    check_idle("unit_idle", 4);

    // Max positive products wrap without saturation.
    fill(16'h7FFF, 16'h7FFF, 1'b0);
    run_pass(99, 0, 1'b0);
    verify_pass("wrap", 99, 0);
    check("wrap_n0_const", 64'(hs_data[0]), 64'h00000000012198B4);

    // Backpressure on neuron 3 for five cycles.
    fill(0, 0, 1'b1);
    run_pass(3, 5, 1'b0);
    verify_pass("stall", 3, 5);

    // Reset in the middle of neuron 5's MAC.
    fill(0, 0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    hs = 0; seen_done = 0;
    for (int c = 0; c < 200 && hs < 5; c++) begin
      outReady = 1'b1;
      if (outValid) hs++;
      if (done) seen_done++;
      tick();
    end
    check("rst_reach_n5", 64'(hs), 64'd5);
    tick(); tick();
    check("rst_mid_mac_wadr", 64'(wAdr), 64'(5*N_IN + 2));
    rst = 1'b1;
    #1;
    check("rst_async_zero", {busy, done, outValid, outData, outIdx, featAdr, wAdr, biasAdr, classIdx, classValid}, 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) seen_done++;
      tick();
    end
    check("rst_no_done", 64'(seen_done), 64'd0);
    run_pass(99, 0, 1'b0);
    verify_pass("after_rst", 99, 0);

    // start re-pulsed in MAC and in DONE is ignored.
    fill(0, 0, 1'b1);
    run_pass(99, 0, 1'b1);
    verify_pass("repulse", 99, 0);
    check_idle("repulse_idle", 8);

    // Zero weights: scores equal the biases.
    load_real_bias();
    fill(0, 0, 1'b0);
    for (int i = 0; i < N_IN; i++) feat[i] = 16'($urandom);
    run_pass(99, 0, 1'b0);
    verify_pass("zero_w", 99, 0);
`ifdef ARGMAX_EN
    check("zero_w_class_const", 64'(ci_at_done), 64'd1);
`endif

    // Random data, random biases, random stall.
    for (int p = 0; p < 3; p++) begin
      int sk, sl;
      fill(0, 0, 1'b1);
      for (int n = 0; n < N_OUT; n++) bias[n] = $urandom;
      sk = int'($urandom_range(0, N_OUT-1));
      sl = int'($urandom_range(0, 6));
      run_pass(sk, sl, 1'b0);
      verify_pass($sformatf("rand%0d", p), sk, sl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
